// File: rtl/addsub_pipe_if.sv
// ----------------------------------------------------------------------------
// addsub_pipe_if
// Streaming handshake bundle for the pipelined adder/subtractor.
//   Operand side : in_valid, in_ready, a, b, sub, cin
//   Result side  : out_valid, out_ready, sum, cout, ovf
// Modports:
//   master - upstream/downstream environment (drives operands, out_ready)
//   slave  - the arithmetic block (drives in_ready and the result fields)
// ----------------------------------------------------------------------------
interface addsub_pipe_if #(
  parameter int unsigned WIDTH = 8
) ();

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             sub;
  logic             cin;

  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;

  modport master (
    output in_valid, a, b, sub, cin, out_ready,
    input  in_ready, out_valid, sum, cout, ovf
  );

  modport slave (
    input  in_valid, a, b, sub, cin, out_ready,
    output in_ready, out_valid, sum, cout, ovf
  );

endinterface

// File: rtl/addsub_pipe.sv
// ----------------------------------------------------------------------------
// addsub_pipe
// Pipelined ripple adder/subtractor. A WIDTH-bit operation is split into
// STAGES chunks of CHUNK = WIDTH/STAGES bits; each stage adds one chunk and
// registers the carry for the next. Results emerge STAGES cycles after
// acceptance, one beat per cycle, with full backpressure.
//
//   add      : {cout,sum} = a + b + cin
//   subtract : {cout,sum} = a + ~b + ~cin   (cout=1 means no borrow)
//   ovf      : two's-complement signed overflow
//
// Ports:
//   clk    - rising-edge clock
//   rst_n  - asynchronous active-low reset
//   bus    - addsub_pipe_if.slave (operand and result handshakes)
//
// Build option:
//   ADDSUB_SAT_EN - when defined, an overflowing result is clamped to the
//                   signed limit in the final stage (cout/ovf unchanged).
// ----------------------------------------------------------------------------
module addsub_pipe #(
  parameter int unsigned WIDTH  = 8,
  parameter int unsigned STAGES = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  addsub_pipe_if.slave bus
);

  localparam int unsigned CHUNK = WIDTH / STAGES;
  localparam int unsigned CW    = CHUNK + 1;

  // Reject configurations that cannot be split into equal chunks.
  if (WIDTH < 2 || STAGES < 1 || (WIDTH % STAGES) != 0) begin : g_cfg_err
    $error("addsub_pipe: need WIDTH>=2, STAGES>=1, WIDTH %% STAGES == 0");
  end

  // Per-stage pipeline registers: valid, carry, travelling operands and the
  // partially assembled sum. Index k holds the beat after stage k.
  logic [STAGES-1:0]            vld_d, vld_q;
  logic [STAGES-1:0]            cy_d,  cy_q;
  logic [STAGES-1:0][WIDTH-1:0] a_d,   a_q;
  logic [STAGES-1:0][WIDTH-1:0] b_d,   b_q;
  logic [STAGES-1:0][WIDTH-1:0] s_d,   s_q;
  logic                         ovf_d, ovf_q;

  // Whole pipeline moves together unless the result is held by downstream.
  logic advance;
  assign advance = !(vld_q[STAGES-1] && !bus.out_ready);

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    logic             vi;
    logic [WIDTH-1:0] ai;
    logic [WIDTH-1:0] bi;
    logic [WIDTH-1:0] si;
    logic             ci;
    logic [CW-1:0]    part;
    logic [WIDTH-1:0] so;

    // Stage input: the operand port for stage 0, the previous register otherwise.
    if (k == 0) begin : g_first
      assign vi = bus.in_valid;
      assign ai = bus.a;
      assign bi = bus.sub ? ~bus.b : bus.b;
      assign si = '0;
      assign ci = bus.sub ? ~bus.cin : bus.cin;
    end else begin : g_next
      assign vi = vld_q[k-1];
      assign ai = a_q[k-1];
      assign bi = b_q[k-1];
      assign si = s_q[k-1];
      assign ci = cy_q[k-1];
    end

    // One chunk of ripple addition.
    assign part = CW'(ai[k*CHUNK +: CHUNK]) + CW'(bi[k*CHUNK +: CHUNK]) + CW'(ci);

    // Merge the new chunk into the sum travelling with the beat.
    always_comb begin
      so                     = si;
      so[k*CHUNK +: CHUNK]   = part[CHUNK-1:0];
    end

    assign vld_d[k] = vi;
    assign cy_d[k]  = part[CW-1];
    assign a_d[k]   = ai;
    assign b_d[k]   = bi;

    if (k == STAGES - 1) begin : g_last
      logic             ov;
      logic [WIDTH-1:0] sf;

      // Same-sign operands producing a result of the other sign.
      assign ov = (ai[WIDTH-1] == bi[WIDTH-1]) && (so[WIDTH-1] != ai[WIDTH-1]);

`ifdef ADDSUB_SAT_EN
      // Clamp toward the sign of a: 0111..1 or 1000..0.
      assign sf = ov ? {ai[WIDTH-1], {(WIDTH-1){~ai[WIDTH-1]}}} : so;
`else
      assign sf = so;
`endif

      assign ovf_d  = ov;
      assign s_d[k] = sf;
    end else begin : g_mid
      assign s_d[k] = so;
    end
  end

  // Pipeline state; async reset drops every in-flight beat immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q <= '0;
      cy_q  <= '0;
      a_q   <= '0;
      b_q   <= '0;
      s_q   <= '0;
      ovf_q <= 1'b0;
    end else if (advance) begin
      vld_q <= vld_d;
      cy_q  <= cy_d;
      a_q   <= a_d;
      b_q   <= b_d;
      s_q   <= s_d;
      ovf_q <= ovf_d;
    end
  end

  // Lower operand chunks are dead once consumed; keep them tied off as a group.
  logic unused_operand_bits;
  assign unused_operand_bits = ^{a_q, b_q};

  assign bus.in_ready  = advance;
  assign bus.out_valid = vld_q[STAGES-1];
  assign bus.sum       = s_q[STAGES-1];
  assign bus.cout      = cy_q[STAGES-1];
  assign bus.ovf       = ovf_q;

endmodule

// File: tb/tb_addsub_pipe.sv
// ----------------------------------------------------------------------------
// tb_addsub_pipe
// Self-checking bench for addsub_pipe (WIDTH=8, STAGES=2): reset values,
// a table of hand-computed vectors with latency checks, a backpressured
// random stream against a scoreboard, and a mid-stream reset.
// ----------------------------------------------------------------------------
module tb_addsub_pipe;

  localparam int unsigned W  = 8;
  localparam int unsigned ST = 2;
  localparam int unsigned NV = 12;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         sub;
    logic         cin;
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;
  } vec_t;

  typedef struct {
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;
  } res_t;

  logic clk;
  logic rst_n;

  addsub_pipe_if #(.WIDTH(W)) bus ();

  addsub_pipe #(.WIDTH(W), .STAGES(ST)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int   n_checks = 0;
  int   n_fail   = 0;
  int   n_out    = 0;
  int   n_stall  = 0;
  int   mon_cyc  = 0;
  logic prev_stall = 1'b0;
  res_t exp_q[$];
  res_t drv_exp;
  res_t mon_r;
  vec_t vecs[NV];

  task automatic check(input string nm, input int idx, input logic [31:0] act,
                       input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s[%0d]: got 0x%0h, want 0x%0h", nm, idx, act, exp);
    end
  endtask

  function automatic logic [W-1:0] pick(input logic [W-1:0] wrap, input logic [W-1:0] clamp);
`ifdef ADDSUB_SAT_EN
    return clamp;
`else
    return wrap;
`endif
  endfunction

  function automatic vec_t mk(input logic [W-1:0] a, input logic [W-1:0] b,
                              input logic sub, input logic cin,
                              input logic [W-1:0] s, input logic co, input logic ov);
    vec_t v;
    v.a = a; v.b = b; v.sub = sub; v.cin = cin;
    v.sum = s; v.cout = co; v.ovf = ov;
    return v;
  endfunction

  // Reference: plain integer arithmetic, unsigned for carry, signed for overflow.
  function automatic res_t model(input logic [W-1:0] a, input logic [W-1:0] b,
                                 input logic sub, input logic cin);
    res_t r;
    int ua, ub, sa, sb, u, s;
    ua = int'(a);
    ub = int'(b);
    sa = int'($signed(a));
    sb = int'($signed(b));
    if (sub) begin
      u = ua - ub - int'(cin);
      s = sa - sb - int'(cin);
      r.cout = (u >= 0);
    end else begin
      u = ua + ub + int'(cin);
      s = sa + sb + int'(cin);
      r.cout = (u > 255);
    end
    r.sum = W'(u);
    r.ovf = (s > 127) || (s < -128);
`ifdef ADDSUB_SAT_EN
    if (r.ovf) r.sum = (s > 0) ? 8'h7F : 8'h80;
`endif
    return r;
  endfunction

  // Scoreboard monitor, sampled mid-cycle.
  always @(negedge clk) begin
    mon_cyc++;
    if (!rst_n) begin
      prev_stall = 1'b0;
    end else begin
      check("in_ready", mon_cyc, 32'(bus.in_ready), 32'(!bus.out_valid || bus.out_ready));
      if (prev_stall) check("hold_valid", mon_cyc, 32'(bus.out_valid), 32'd1);
      if (bus.out_valid && !bus.out_ready) begin
        n_stall++;
        if (exp_q.size() != 0) begin
          check("hold_sum",  mon_cyc, 32'(bus.sum),  32'(exp_q[0].sum));
          check("hold_cout", mon_cyc, 32'(bus.cout), 32'(exp_q[0].cout));
          check("hold_ovf",  mon_cyc, 32'(bus.ovf),  32'(exp_q[0].ovf));
        end else begin
          n_checks++;
          n_fail++;
          $display("FAIL stalled_unexpected[%0d]: got out_valid=1, want no result", mon_cyc);
        end
      end
      if (bus.out_valid && bus.out_ready) begin
        n_out++;
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_out[%0d]: got sum=0x%0h, want no result", mon_cyc, bus.sum);
        end else begin
          mon_r = exp_q.pop_front();
          check("sb_sum",  n_out, 32'(bus.sum),  32'(mon_r.sum));
          check("sb_cout", n_out, 32'(bus.cout), 32'(mon_r.cout));
          check("sb_ovf",  n_out, 32'(bus.ovf),  32'(mon_r.ovf));
        end
      end
      if (bus.in_valid && bus.in_ready) exp_q.push_back(drv_exp);
      prev_stall = bus.out_valid && !bus.out_ready;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog[0]: got timeout, want end of test");
    $fatal(1, "watchdog");
  end

  initial begin
    int   lat;
    logic got;
    int   idx;
    int   cyc;
    int   n_out0;
    int   n_stall0;
    logic acc;
    logic [W-1:0] ra[6];
    logic [W-1:0] rb[6];
    logic         rs[6];
    logic         rc[6];

    vecs[0]  = mk(8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
    vecs[1]  = mk(8'h0F, 8'h01, 1'b0, 1'b0, 8'h10, 1'b0, 1'b0);
    vecs[2]  = mk(8'h7F, 8'h01, 1'b0, 1'b0, pick(8'h80, 8'h7F), 1'b0, 1'b1);
    vecs[3]  = mk(8'h05, 8'h07, 1'b1, 1'b0, 8'hFE, 1'b0, 1'b0);
    vecs[4]  = mk(8'h80, 8'h01, 1'b1, 1'b0, pick(8'h7F, 8'h80), 1'b1, 1'b1);
    vecs[5]  = mk(8'h3C, 8'h05, 1'b0, 1'b1, 8'h42, 1'b0, 1'b0);
    vecs[6]  = mk(8'h10, 8'h10, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0);
    vecs[7]  = mk(8'h10, 8'h0F, 1'b1, 1'b1, 8'h00, 1'b1, 1'b0);
    vecs[8]  = mk(8'h80, 8'h80, 1'b0, 1'b0, pick(8'h00, 8'h80), 1'b1, 1'b1);
    vecs[9]  = mk(8'h00, 8'h01, 1'b1, 1'b1, 8'hFE, 1'b0, 1'b0);
    vecs[10] = mk(8'h7F, 8'h80, 1'b1, 1'b0, pick(8'hFF, 8'h7F), 1'b0, 1'b1);
    vecs[11] = mk(8'hC8, 8'h38, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0);

    // Reset held with a pending operand.
    rst_n         = 1'b0;
    bus.in_valid  = 1'b1;
    bus.a         = 8'h55;
    bus.b         = 8'hAA;
    bus.sub       = 1'b0;
    bus.cin       = 1'b1;
    bus.out_ready = 1'b1;
    drv_exp       = '{sum: '0, cout: 1'b0, ovf: 1'b0};
    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid", 0, 32'(bus.out_valid), 32'd0);
    check("rst_sum",       0, 32'(bus.sum),       32'd0);
    check("rst_cout",      0, 32'(bus.cout),      32'd0);
    check("rst_ovf",       0, 32'(bus.ovf),       32'd0);
    check("rst_in_ready",  0, 32'(bus.in_ready),  32'd1);
    bus.in_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk);
      #1;
      check("idle_out_valid", i, 32'(bus.out_valid), 32'd0);
    end

    // Directed vectors, one beat each, with latency measurement.
    for (int i = 0; i < int'(NV); i++) begin
      bus.a        = vecs[i].a;
      bus.b        = vecs[i].b;
      bus.sub      = vecs[i].sub;
      bus.cin      = vecs[i].cin;
      drv_exp      = '{sum: vecs[i].sum, cout: vecs[i].cout, ovf: vecs[i].ovf};
      bus.in_valid = 1'b1;
      lat = 0;
      got = 1'b0;
      while (!got && lat < 8) begin
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        lat++;
        got = bus.out_valid;
      end
      check("vec_latency", i, 32'(lat),       32'(ST));
      check("vec_sum",     i, 32'(bus.sum),   32'(vecs[i].sum));
      check("vec_cout",    i, 32'(bus.cout),  32'(vecs[i].cout));
      check("vec_ovf",     i, 32'(bus.ovf),   32'(vecs[i].ovf));
    end
    @(posedge clk);
    #1;
    check("vec_drained", 0, 32'(bus.out_valid), 32'd0);
    check("vec_sb_empty", 0, 32'(exp_q.size()), 32'd0);

    // Back-to-back random stream with a 3-cycle downstream stall.
    for (int i = 0; i < 6; i++) begin
      ra[i] = W'($urandom_range(0, 255));
      rb[i] = W'($urandom_range(0, 255));
      rs[i] = 1'($urandom_range(0, 1));
      rc[i] = 1'($urandom_range(0, 1));
    end
    n_out0   = n_out;
    n_stall0 = n_stall;
    idx      = 0;
    cyc      = 0;
    while ((idx < 6 || exp_q.size() != 0) && cyc < 60) begin
      bus.out_ready = !(cyc >= 3 && cyc < 6);
      if (idx < 6) begin
        bus.a        = ra[idx];
        bus.b        = rb[idx];
        bus.sub      = rs[idx];
        bus.cin      = rc[idx];
        drv_exp      = model(ra[idx], rb[idx], rs[idx], rc[idx]);
        bus.in_valid = 1'b1;
      end else begin
        bus.in_valid = 1'b0;
      end
      @(negedge clk);
      acc = bus.in_valid && bus.in_ready;
      @(posedge clk);
      #1;
      if (acc) idx++;
      cyc++;
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    check("bp_finished",   0, 32'(idx == 6 && exp_q.size() == 0), 32'd1);
    check("bp_outputs",    0, 32'(n_out - n_out0),     32'd6);
    check("bp_stall_cyc",  0, 32'(n_stall - n_stall0), 32'd3);

    // Reset with two beats in flight.
    n_out0        = n_out;
    bus.out_ready = 1'b0;
    bus.a = 8'h12; bus.b = 8'h34; bus.sub = 1'b0; bus.cin = 1'b0;
    drv_exp      = model(8'h12, 8'h34, 1'b0, 1'b0);
    bus.in_valid = 1'b1;
    @(posedge clk);
    #1;
    bus.a = 8'h56; bus.b = 8'h78; bus.sub = 1'b1; bus.cin = 1'b1;
    drv_exp = model(8'h56, 8'h78, 1'b1, 1'b1);
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    check("mid_pre_valid", 0, 32'(bus.out_valid), 32'd1);
    check("mid_pre_sum",   0, 32'(bus.sum),       32'h46);
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_rst_valid",    0, 32'(bus.out_valid), 32'd0);
    check("mid_rst_in_ready", 0, 32'(bus.in_ready),  32'd1);
    exp_q.delete();
    @(posedge clk);
    #2;
    rst_n         = 1'b1;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk);
      #1;
      check("mid_post_valid", i, 32'(bus.out_valid), 32'd0);
    end
    check("mid_post_outputs", 0, 32'(n_out - n_out0), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
